// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, write-first bypass and r0 tied to zero.
// Define REGFILE_SCOREBOARD_EN to add the pending-write scoreboard (iss_en/iss_addr/rd_busy).
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [NUM_RD-1:0]          rd_busy
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;

  // Issue is applied after the write clear so a new producer supersedes the old one.
  always_comb begin
    pending_nxt = pending;
    if (we) pending_nxt[wa] = 1'b0;
    if (iss_en && (iss_addr != '0)) pending_nxt[iss_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end
`endif

  // Handshake: re[i] is a request with no ready (always accepted); rd_valid[i]
  // pulses for exactly one cycle after each accepted request, and rd_data/rd_busy
  // hold their last captured values while re[i] is low.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    logic              hit;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign ra_i = ra[i*ADDR_W +: ADDR_W];
    assign hit  = we && (wa == ra_i);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= re[i];
        if (re[i]) begin
          if (ra_i == '0) data_q <= '0;
          else if (hit)   data_q <= wd;
          else            data_q <= mem[ra_i];
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data_q;
    assign rd_valid[i]                 = valid_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic busy_q;

    // Sample the pre-issue pending state; a same-cycle write satisfies the hazard.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     busy_q <= 1'b0;
      else if (re[i]) busy_q <= pending[ra_i] & ~hit;
    end

    assign rd_busy[i] = busy_q;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (two read ports, 32x32).
// Scoreboard checks run only when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [1:0]  re;
  logic [9:0]  ra;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
`ifdef REGFILE_SCOREBOARD_EN
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [1:0]  rd_busy;
`endif

  int tests  = 0;
  int failed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_exp [2];

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .re       (re),
    .ra       (ra),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_busy  (rd_busy)
`endif
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; expected read data goes through exp_q, held ports keep last_exp.
  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1, input string tag);
    we = w; wa = a; wd = d; re = r; ra = {a1, a0};
    if (r[0]) exp_q.push_back(e0);
    if (r[1]) exp_q.push_back(e1);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (r[i]) last_exp[i] = exp_q.pop_front();
      check($sformatf("%s_d%0d", tag, i), {32'h0, rd_data[i*32 +: 32]}, {32'h0, last_exp[i]});
      check($sformatf("%s_v%0d", tag, i), {63'h0, rd_valid[i]}, {63'h0, r[i]});
    end
    we = 1'b0; re = 2'b00;
  endtask

  // Called #1 after a posedge: drops rst_n between edges and checks outputs clear at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_d"}, rd_data, 64'h0);
    check({tag, "_v"}, {62'h0, rd_valid}, 64'h0);
`ifdef REGFILE_SCOREBOARD_EN
    check({tag, "_b"}, {62'h0, rd_busy}, 64'h0);
    iss_en = 1'b0;
`endif
    last_exp[0] = '0; last_exp[1] = '0;
    we = 1'b0; re = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; wa = '0; wd = '0; re = '0; ra = '0;
    last_exp[0] = '0; last_exp[1] = '0;
`ifdef REGFILE_SCOREBOARD_EN
    iss_en = 1'b0; iss_addr = '0;
`endif
    // reset held across edges with activity on the inputs
    #2 rst_n = 1'b0;
    we = 1'b1; wa = 5'd3; wd = 32'h1111_2222; re = 2'b11; ra = {5'd3, 5'd3};
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_d", rd_data, 64'h0);
    check("rst_hold_v", {62'h0, rd_valid}, 64'h0);
    we = 1'b0; re = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 32'h0, 32'h0, "post_rst_r3");

    // fill a few registers, reset mid-stream, then sweep every address
    drive(1'b1, 5'd3,  32'hA5A5_A5A5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, "fill3");
    drive(1'b1, 5'd31, 32'h0000_0001, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, "fill31");
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd31, 32'hA5A5_A5A5, 32'h0000_0001, "fill_rd");
    async_reset("arst_stream");
    for (int a = 0; a < 32; a++)
      drive(1'b0, 5'd0, 32'h0, 2'b11, a[4:0], 5'(31 - a), 32'h0, 32'h0, $sformatf("sweep%0d", a));

    // address 0 ignores writes, including the same-cycle bypass path
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 2'b01, 5'd0, 5'd0, 32'h0, 32'h0, "wr0_byp");
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, "wr0_rd");

    // basic write then read
    drive(1'b1, 5'd5, 32'h1234_5678, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, "basic_wr");
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd6, 32'h1234_5678, 32'h0, "basic");

    // bypass, both ports reading the address being written
    drive(1'b1, 5'd9, 32'hCAFE_F00D, 2'b11, 5'd9, 5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, "bypass");
    drive(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 32'h0, 32'hCAFE_F00D, "bypass_mem");

    // hold while re is low, even as the register changes underneath
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 32'h1234_5678, 32'h0, "hold_rd");
    for (int n = 0; n < 3; n++)
      drive(1'b1, 5'd5, 32'h0000_0001, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, $sformatf("hold%0d", n));
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 32'h0000_0001, 32'h0, "hold_new");

    // async reset right after a read
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 32'hCAFE_F00D, 32'h0, "pre_arst");
    async_reset("arst_read");
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd5, 32'h0, 32'h0, "post_arst");

`ifdef REGFILE_SCOREBOARD_EN
    iss_en = 1'b1; iss_addr = 5'd7;
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, "sb_iss7");
    iss_en = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 32'h0, 32'h0, "sb_rd7");
    check("sb_busy7", {63'h0, rd_busy[0]}, 64'h1);
    drive(1'b1, 5'd7, 32'h0000_0077, 2'b01, 5'd7, 5'd0, 32'h0000_0077, 32'h0, "sb_wr7");
    check("sb_wr_clr", {63'h0, rd_busy[0]}, 64'h0);
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 32'h0000_0077, 32'h0, "sb_rd7b");
    check("sb_cleared", {63'h0, rd_busy[0]}, 64'h0);
    // issue and write to the same register: set wins
    iss_en = 1'b1; iss_addr = 5'd7;
    drive(1'b1, 5'd7, 32'h0000_0088, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, "sb_both7");
    iss_en = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 32'h0000_0088, 32'h0, "sb_rd7c");
    check("sb_setwins", {63'h0, rd_busy[0]}, 64'h1);
    // same-cycle issue is not visible to the read it accompanies
    iss_en = 1'b1; iss_addr = 5'd8;
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd8, 5'd0, 32'h0, 32'h0, "sb_iss8");
    iss_en = 1'b0;
    check("sb_same_cyc", {63'h0, rd_busy[0]}, 64'h0);
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd8, 5'd0, 32'h0, 32'h0, "sb_rd8");
    check("sb_busy8", {63'h0, rd_busy[0]}, 64'h1);
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, "sb_idle");
    check("sb_hold", {63'h0, rd_busy[0]}, 64'h1);
    // issue to r0 never marks it pending
    iss_en = 1'b1; iss_addr = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, "sb_iss0");
    iss_en = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h0, "sb_rd0");
    check("sb_busy0", {63'h0, rd_busy[1]}, 64'h0);
    async_reset("sb_arst");
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd8, 32'h0, 32'h0, "sb_post_rst");
    check("sb_post_rst_b", {62'h0, rd_busy}, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
